// File: rtl/riscv_pkg.sv
// Shared RISC-V encodings plus the per-edge action codes of the fetch latency model.
package riscv_pkg;

  localparam logic [31:0] NopInstr = 32'h0000_0013;  // addi x0, x0, 0

  localparam int unsigned MinFetchLatency = 1;
  localparam int unsigned MaxFetchLatency = 8;

  typedef enum logic [1:0] {
    FetchNormal = 2'd0,
    FetchBubble = 2'd1,
    FetchHold   = 2'd2,
    FetchFlush  = 2'd3
  } fetch_action_e;

endpackage

// File: rtl/sim_fetch_stage_reg.sv
// One slot of the fetch delay chain: load, hold, or clear to CLR_VAL; async reset also to CLR_VAL.
module sim_fetch_stage_reg
  import riscv_pkg::*;
#(
  parameter int unsigned      WIDTH   = 1,
  parameter logic [WIDTH-1:0] CLR_VAL = '0
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             load_i,
  input  logic             clear_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] slot_d;
  logic [WIDTH-1:0] slot_q;

  // Clear wins over load; neither means hold.
  always_comb begin
    slot_d = slot_q;
    if (clear_i) begin
      slot_d = CLR_VAL;
    end else if (load_i) begin
      slot_d = d_i;
    end else begin
      slot_d = slot_q;
    end
  end

  // Slot storage.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      slot_q <= CLR_VAL;
    end else begin
      slot_q <= slot_d;
    end
  end

  assign q_o = slot_q;

endmodule

// File: rtl/sim_fetch_latency_model.sv
// Simulation fetch memory model: LATENCY-deep chain of {vld, pc, instr} slots with
// stall-hold, flush and bubble injection between the bench instruction source and the CPU.
module sim_fetch_latency_model
  import riscv_pkg::*;
#(
  parameter int unsigned INSTR_WIDTH   = 32,
  parameter int unsigned LATENCY       = 1,
  parameter bit          HOLD_ON_STALL = 1'b1
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic [31:0]            i_pc,
  input  logic [INSTR_WIDTH-1:0] i_instr_from_tb,
  input  logic                   i_stall,
  input  logic                   i_flush,
  input  logic                   i_inject_bubble,
  output logic [INSTR_WIDTH-1:0] o_instr,
  output logic [31:0]            o_instr_pc,
  output logic                   o_instr_vld,
  output logic                   o_stall_q,
  output logic [15:0]            o_bubble_count
);

  if (LATENCY < MinFetchLatency || LATENCY > MaxFetchLatency) begin : g_bad_latency
    $error("sim_fetch_latency_model: LATENCY must be within 1..8");
  end

  typedef struct packed {
    logic                   vld;
    logic [31:0]            pc;
    logic [INSTR_WIDTH-1:0] instr;
  } fetch_slot_t;

  localparam int unsigned      SlotWidth = $bits(fetch_slot_t);
  localparam logic [INSTR_WIDTH-1:0] NopWord = INSTR_WIDTH'(NopInstr);
  localparam fetch_slot_t      EmptySlot = '{vld: 1'b0, pc: 32'h0000_0000, instr: NopWord};

  fetch_action_e action;
  logic          stage_load;
  logic          stage_clear;
  fetch_slot_t   head_slot;
  fetch_slot_t   last_slot;
  fetch_slot_t   stage_in  [LATENCY];
  fetch_slot_t   stage_out [LATENCY];

  logic          stall_q;
  logic [15:0]   bubble_count_d;
  logic [15:0]   bubble_count_q;

  // Resolve this edge's action: flush > stall-hold > bubble > normal.
  always_comb begin
    action = FetchNormal;
    if (i_flush) begin
      action = FetchFlush;
    end else if (HOLD_ON_STALL && i_stall) begin
      action = FetchHold;
    end else if (i_inject_bubble) begin
      action = FetchBubble;
    end else begin
      action = FetchNormal;
    end
  end

  // Chain controls and the record captured by stage 0.
  always_comb begin
    stage_load  = 1'b0;
    stage_clear = 1'b0;
    head_slot   = '{vld: 1'b1, pc: i_pc, instr: i_instr_from_tb};
    case (action)
      FetchNormal: begin
        stage_load = 1'b1;
      end
      FetchBubble: begin
        stage_load = 1'b1;
        head_slot  = '{vld: 1'b0, pc: i_pc, instr: NopWord};
      end
      FetchFlush: begin
        stage_clear = 1'b1;
      end
      FetchHold: begin
        stage_load = 1'b0;
      end
      default: begin
        stage_load  = 1'b0;
        stage_clear = 1'b0;
      end
    endcase
  end

  for (genvar g = 0; g < LATENCY; g++) begin : g_stage
    if (g == 0) begin : g_head
      assign stage_in[g] = head_slot;
    end else begin : g_link
      assign stage_in[g] = stage_out[g-1];
    end

    sim_fetch_stage_reg #(
      .WIDTH   (SlotWidth),
      .CLR_VAL (EmptySlot)
    ) u_stage (
      .clk_i   (i_clk),
      .rst_i   (i_rst),
      .load_i  (stage_load),
      .clear_i (stage_clear),
      .d_i     (stage_in[g]),
      .q_o     (stage_out[g])
    );
  end

  // Only bubbles that actually enter the chain are counted; saturate rather than wrap.
  always_comb begin
    bubble_count_d = bubble_count_q;
    if (action == FetchBubble && bubble_count_q != 16'hFFFF) begin
      bubble_count_d = bubble_count_q + 16'd1;
    end else begin
      bubble_count_d = bubble_count_q;
    end
  end

  // Stall delay and bubble counter.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      stall_q        <= 1'b0;
      bubble_count_q <= 16'h0000;
    end else begin
      stall_q        <= i_stall;
      bubble_count_q <= bubble_count_d;
    end
  end

  assign last_slot      = stage_out[LATENCY-1];
  assign o_instr        = last_slot.vld ? last_slot.instr : NopWord;
  assign o_instr_pc     = last_slot.pc;
  assign o_instr_vld    = last_slot.vld;
  assign o_stall_q      = stall_q;
  assign o_bubble_count = bubble_count_q;

endmodule

// File: tb/tb_sim_fetch_latency_model.sv
// Directed self-checking bench: four model instances (latency 1..4) share one stimulus stream;
// each phase checks the instance whose configuration it targets.
module tb_sim_fetch_latency_model;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] pc = 32'h0;
  logic [31:0] instr = 32'h0;
  logic        stall = 1'b0;
  logic        flush = 1'b0;
  logic        bubble = 1'b0;

  logic [31:0] l1_instr, l2_instr, l3_instr, l4_instr;
  logic [31:0] l1_pc, l2_pc, l3_pc, l4_pc;
  logic        l1_vld, l2_vld, l3_vld, l4_vld;
  logic        l1_sq, l2_sq, l3_sq, l4_sq;
  logic [15:0] l1_cnt, l2_cnt, l3_cnt, l4_cnt;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  sim_fetch_latency_model #(.INSTR_WIDTH(32), .LATENCY(1), .HOLD_ON_STALL(1'b0)) u_lat1 (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_instr_from_tb(instr), .i_stall(stall),
    .i_flush(flush), .i_inject_bubble(bubble), .o_instr(l1_instr), .o_instr_pc(l1_pc),
    .o_instr_vld(l1_vld), .o_stall_q(l1_sq), .o_bubble_count(l1_cnt));

  sim_fetch_latency_model #(.INSTR_WIDTH(32), .LATENCY(2), .HOLD_ON_STALL(1'b1)) u_lat2 (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_instr_from_tb(instr), .i_stall(stall),
    .i_flush(flush), .i_inject_bubble(bubble), .o_instr(l2_instr), .o_instr_pc(l2_pc),
    .o_instr_vld(l2_vld), .o_stall_q(l2_sq), .o_bubble_count(l2_cnt));

  sim_fetch_latency_model #(.INSTR_WIDTH(32), .LATENCY(3), .HOLD_ON_STALL(1'b1)) u_lat3 (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_instr_from_tb(instr), .i_stall(stall),
    .i_flush(flush), .i_inject_bubble(bubble), .o_instr(l3_instr), .o_instr_pc(l3_pc),
    .o_instr_vld(l3_vld), .o_stall_q(l3_sq), .o_bubble_count(l3_cnt));

  sim_fetch_latency_model #(.INSTR_WIDTH(32), .LATENCY(4), .HOLD_ON_STALL(1'b1)) u_lat4 (
    .i_clk(clk), .i_rst(rst), .i_pc(pc), .i_instr_from_tb(instr), .i_stall(stall),
    .i_flush(flush), .i_inject_bubble(bubble), .o_instr(l4_instr), .o_instr_pc(l4_pc),
    .o_instr_vld(l4_vld), .o_stall_q(l4_sq), .o_bubble_count(l4_cnt));

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [31:0] p, input logic [31:0] w, input logic s,
                       input logic f, input logic b);
    pc = p; instr = w; stall = s; flush = f; bubble = b;
  endtask

  // Advance one edge and settle away from it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check_eq({tag, " l1"}, {l1_instr, l1_pc, l1_vld, l1_sq, l1_cnt}, {32'h13, 32'h0, 1'b0, 1'b0, 16'h0});
    check_eq({tag, " l2"}, {l2_instr, l2_pc, l2_vld, l2_sq, l2_cnt}, {32'h13, 32'h0, 1'b0, 1'b0, 16'h0});
    check_eq({tag, " l3"}, {l3_instr, l3_pc, l3_vld, l3_sq, l3_cnt}, {32'h13, 32'h0, 1'b0, 1'b0, 16'h0});
    check_eq({tag, " l4"}, {l4_instr, l4_pc, l4_vld, l4_sq, l4_cnt}, {32'h13, 32'h0, 1'b0, 1'b0, 16'h0});
  endtask

  initial begin
    #1;
    check_reset_state("reset_at_start");

    // Latency 3: A/B/C enter at edges 1..3, first emerges after edge 3.
    do_reset();
    drive(32'h0, 32'hA, 1'b0, 1'b0, 1'b0); tick();
    drive(32'h4, 32'hB, 1'b0, 1'b0, 1'b0); tick();
    check_eq("lat3 not_yet_vld", l3_vld, 1'b0);
    check_eq("lat3 not_yet_nop", l3_instr, 32'h13);
    drive(32'h8, 32'hC, 1'b0, 1'b0, 1'b0); tick();
    check_eq("lat3 word_a", {l3_vld, l3_pc, l3_instr}, {1'b1, 32'h0, 32'hA});
    drive(32'hC, 32'hD, 1'b0, 1'b0, 1'b0); tick();
    check_eq("lat3 word_b", {l3_vld, l3_pc, l3_instr}, {1'b1, 32'h4, 32'hB});
    tick();
    check_eq("lat3 word_c", {l3_vld, l3_pc, l3_instr}, {1'b1, 32'h8, 32'hC});

    // Latency 2 with two stall cycles: w0 held for three cycles, then w1, w2.
    do_reset();
    drive(32'h100, 32'h1000, 1'b0, 1'b0, 1'b0); tick();
    drive(32'h104, 32'h1001, 1'b0, 1'b0, 1'b0); tick();
    check_eq("stall w0_c1", {l2_vld, l2_pc, l2_instr, l2_sq}, {1'b1, 32'h100, 32'h1000, 1'b0});
    drive(32'h108, 32'h1002, 1'b1, 1'b0, 1'b0); tick();
    check_eq("stall w0_c2", {l2_vld, l2_pc, l2_instr, l2_sq}, {1'b1, 32'h100, 32'h1000, 1'b1});
    tick();
    check_eq("stall w0_c3", {l2_vld, l2_pc, l2_instr, l2_sq}, {1'b1, 32'h100, 32'h1000, 1'b1});
    drive(32'h108, 32'h1002, 1'b0, 1'b0, 1'b0); tick();
    check_eq("stall w1", {l2_vld, l2_pc, l2_instr, l2_sq}, {1'b1, 32'h104, 32'h1001, 1'b0});
    drive(32'h10C, 32'h1003, 1'b0, 1'b0, 1'b0); tick();
    check_eq("stall w2", {l2_vld, l2_pc, l2_instr}, {1'b1, 32'h108, 32'h1002});

    // Latency 4: four words in flight, flush, first post-flush word 4 edges after capture.
    do_reset();
    for (int k = 0; k < 4; k++) begin
      drive(32'h200 + 32'(4 * k), 32'h2000 + 32'(k), 1'b0, 1'b0, 1'b0);
      tick();
    end
    check_eq("flush pre_w0", {l4_vld, l4_pc, l4_instr}, {1'b1, 32'h200, 32'h2000});
    drive(32'h210, 32'h2004, 1'b0, 1'b1, 1'b0); tick();
    check_eq("flush cleared", {l4_vld, l4_pc, l4_instr}, {1'b0, 32'h0, 32'h13});
    drive(32'h214, 32'h2005, 1'b0, 1'b0, 1'b0); tick();
    drive(32'h218, 32'h2006, 1'b0, 1'b0, 1'b0); tick();
    drive(32'h21C, 32'h2007, 1'b0, 1'b0, 1'b0); tick();
    check_eq("flush still_empty", {l4_vld, l4_instr}, {1'b0, 32'h13});
    drive(32'h220, 32'h2008, 1'b0, 1'b0, 1'b0); tick();
    check_eq("flush first_new", {l4_vld, l4_pc, l4_instr}, {1'b1, 32'h214, 32'h2005});

    // Latency 2 bubbles: one inserted, one dropped under stall, one inserted, one dropped under flush.
    do_reset();
    drive(32'h300, 32'h3000, 1'b0, 1'b0, 1'b1); tick();
    drive(32'h304, 32'h3001, 1'b0, 1'b0, 1'b0); tick();
    check_eq("bub slot1", {l2_vld, l2_pc, l2_instr, l2_cnt}, {1'b0, 32'h300, 32'h13, 16'd1});
    drive(32'h308, 32'h3002, 1'b1, 1'b0, 1'b1); tick();
    check_eq("bub stall_drop", {l2_vld, l2_pc, l2_cnt}, {1'b0, 32'h300, 16'd1});
    drive(32'h308, 32'h3002, 1'b0, 1'b0, 1'b1); tick();
    check_eq("bub real_word", {l2_vld, l2_pc, l2_instr, l2_cnt}, {1'b1, 32'h304, 32'h3001, 16'd2});
    drive(32'h30C, 32'h3003, 1'b0, 1'b0, 1'b0); tick();
    check_eq("bub slot2", {l2_vld, l2_pc, l2_instr}, {1'b0, 32'h308, 32'h13});
    drive(32'h310, 32'h3004, 1'b0, 1'b0, 1'b0); tick();
    check_eq("bub after", {l2_vld, l2_pc, l2_instr, l2_cnt}, {1'b1, 32'h30C, 32'h3003, 16'd2});
    drive(32'h314, 32'h3005, 1'b0, 1'b1, 1'b1); tick();
    check_eq("bub flush_drop", {l2_vld, l2_cnt}, {1'b0, 16'd2});

    // Refill, stall, then assert reset mid-cycle: outputs must clear without an edge.
    drive(32'h318, 32'h3006, 1'b0, 1'b0, 1'b0); tick();
    drive(32'h31C, 32'h3007, 1'b0, 1'b0, 1'b0); tick();
    drive(32'h320, 32'h3008, 1'b1, 1'b0, 1'b0); tick();
    check_eq("midrst before", {l2_vld, l2_pc, l2_instr, l2_sq}, {1'b1, 32'h318, 32'h3006, 1'b1});
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("midrst async");
    tick();
    rst = 1'b0;

    // Saturation: bubbles every cycle up to 0xFFFE, then three more must stick at 0xFFFF.
    drive(32'h500, 32'h5000, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < 65534; k++) tick();
    check_eq("sat fffe", l2_cnt, 16'hFFFE);
    check_eq("sat vld_low", l2_vld, 1'b0);
    for (int k = 0; k < 3; k++) begin
      tick();
      check_eq("sat ffff", l2_cnt, 16'hFFFF);
    end

    // Legacy: latency 1, stall ignored, output equals input one edge later.
    do_reset();
    for (int k = 0; k < 6; k++) begin
      drive(32'h400 + 32'(4 * k), 32'h4000 + 32'(k), k[0], 1'b0, 1'b0);
      tick();
      check_eq("legacy word", {l1_vld, l1_pc, l1_instr}, {1'b1, 32'h400 + 32'(4 * k), 32'h4000 + 32'(k)});
      check_eq("legacy stall_q", l1_sq, k[0]);
    end
    drive(32'h418, 32'h4006, 1'b1, 1'b0, 1'b1); tick();
    check_eq("legacy bubble_in_stall", {l1_vld, l1_pc, l1_instr, l1_cnt}, {1'b0, 32'h418, 32'h13, 16'd1});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sim_fetch_latency_model.md
# sim_fetch_latency_model

Simulation-only instruction-fetch memory model that sits between the testbench instruction source and the CPU `i_instr` port. It generalises the fixed one-cycle block-RAM latency to a parametrised depth, carries the fetch PC alongside each word, and supports three further behaviours: hold-on-stall, flush, and bubble (wait-state) injection. Verification can therefore exercise the fetch path under slower memories and irregular instruction delivery without changing the CPU.

## Interface

Parameters:
- `INSTR_WIDTH`, default 32: fetched word width (raw 32-bit, C-extension halves included).
- `LATENCY`, default 1: read latency in cycles; legal range 1..8; elaboration error outside it.
- `HOLD_ON_STALL`, default 1'b1: 1 freezes all stages while `i_stall` is high; 0 advances every cycle (the legacy behaviour).

Ports:
- `i_clk` in 1: clock.
- `i_rst` in 1: reset, asynchronous, active-high.
- `i_pc` in 32: fetch PC driven by the CPU.
- `i_instr_from_tb` in INSTR_WIDTH: word supplied by the testbench for `i_pc`.
- `i_stall` in 1: CPU pipeline stall (combinational).
- `i_flush` in 1: discard all in-flight fetches.
- `i_inject_bubble` in 1: insert one invalid slot this cycle.
- `o_instr` out INSTR_WIDTH: word presented to the CPU.
- `o_instr_pc` out 32: PC associated with `o_instr`.
- `o_instr_vld` out 1: `o_instr` carries a real fetched word.
- `o_stall_q` out 1: `i_stall` registered one cycle.
- `o_bubble_count` out 16: saturating count of bubbles actually inserted.

## Operation

- The model is a chain of `LATENCY` stages. Each stage holds {vld, pc, instr}. Stage 0 captures from the inputs; the output is the last stage.
- Per-edge precedence is reset > flush > stall-hold > bubble > normal.
  - **Flush:** clears vld in every stage. pc/instr are don't-care but are loaded as {0, NOP}. No shift occurs.
  - **Stall-hold** (only when HOLD_ON_STALL=1): every stage keeps its contents.
  - **Bubble:** the chain shifts, and stage 0 loads {vld=0, pc=`i_pc`, instr=NOP}. `o_bubble_count` increments.
  - **Normal:** the chain shifts, and stage 0 loads {1, `i_pc`, `i_instr_from_tb`}.
- When HOLD_ON_STALL=0, `i_stall` is ignored for data movement. `o_stall_q` still tracks it.
- Output masking: when the last stage has vld=0, `o_instr` = NOP (0x0000_0013, `addi x0,x0,0`) regardless of stored data. `o_instr_pc` always shows the stored pc.
- Bubble asserted during stall-hold or flush is dropped and not counted.
- `o_bubble_count` saturates at 16'hFFFF and never wraps.

## Timing

- Reset (async assert, release synchronous to `i_clk`): all stage vld=0, pc=0, instr=NOP. Resulting outputs: `o_instr`=NOP, `o_instr_pc`=0, `o_instr_vld`=0, `o_stall_q`=0, `o_bubble_count`=0.
- Reset mid-operation immediately empties the chain; there is no partial-stage retention.
- Latency: a word captured at edge N appears on the outputs after edge N+LATENCY−1. Registered out means visible in the cycle following edge N+LATENCY−1.
- Every stall cycle (HOLD_ON_STALL=1) extends latency by exactly one cycle per in-flight word. Stalls are lossless and duplicate-free.
- Flush asserted at edge N: `o_instr_vld`=0 from edge N until new words propagate. The first post-flush word captured at edge N+1 emerges after edge N+LATENCY.
- `o_stall_q` = `i_stall` delayed by one edge, independent of HOLD_ON_STALL.
- With LATENCY=1, HOLD_ON_STALL=0 and no flush or bubble, `o_instr` equals the legacy one-register instruction path cycle-for-cycle.

## Structure

- The NOP encoding belongs in `riscv_pkg` as `NopInstr`; add it if absent.
- The stage record type `fetch_slot_t` {vld, pc, instr} is declared in the module, parametrised by INSTR_WIDTH.
- One sub-module, `sim_fetch_stage_reg`: a single stage with load/hold/clear controls and async reset. It is instantiated `LATENCY` times via generate.
- `cpu_tb` successors instantiate this block in place of the inline instruction register, driving `i_stall` from the CPU pipeline-control stall.

## Test plan

- **Latency:** LATENCY=3, HOLD=1; feed pc 0x0/0x4/0x8 with instr 0xA/0xB/0xC. Expect 0xA with pc 0x0 valid after the 3rd edge, then 0xB and 0xC on consecutive cycles.
- **Stall:** LATENCY=2, HOLD=1; stall 2 cycles mid-stream. Expect the output to hold the same word and pc for 3 cycles, with no word lost or duplicated. `o_stall_q` lags `i_stall` by 1.
- **Flush:** LATENCY=4 with 4 words in flight; flush 1 cycle. Expect `o_instr_vld`=0 and `o_instr`=0x13 until the first post-flush word emerges 4 edges after capture.
- **Bubbles:** LATENCY=2; bubble on 3 cycles, one of them during a stall. Expect `o_bubble_count`=2, two NOP/vld=0 slots in the output stream, and `o_instr_pc` equal to the bubble-cycle PCs.
- **Reset and saturation:** reset mid-stream → all outputs at reset values immediately. Preload count 16'hFFFE and inject 3 bubbles → count stays 16'hFFFF.
- **Legacy equivalence:** LATENCY=1, HOLD=0; stall toggling. Expect output equal to the input delayed one edge, ignoring stall.
